mips_multicycle_ctrl: RTL and testbench

Multicycle control FSM that sequences the MIPS datapath (PC, shared instruction/data memory, register file, ALU, sign extender, PC/branch/jump muxes). It replaces the single-cycle opcode decoder: it issues one set of datapath strobes per state, stalls on a memory-ready handshake, and services an external interrupt between instructions. It also keeps a retired-instruction counter for the display path.

---
 rtl/mips_multicycle_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences datapath strobes per state, stalls on
// mem_ready, services an interrupt between instructions, counts retirements.
module mips_multicycle_ctrl #(
    parameter bit          IRQ_ENABLE = 1'b1,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic                 mem_ready,
    input  logic                 interrupt,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic [1:0]           pc_source,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 mem_to_reg,
    output logic                 reg_dst,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 irq_ack,
    output logic                 illegal_op,
    output logic [3:0]           state,
    output logic [CNT_WIDTH-1:0] retired
);

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_IRQ    = 4'd12
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   retired_q;
    logic                   irq_mask_q;
    logic                   irq_take_c;
    logic                   retire_c;

    assign irq_take_c = IRQ_ENABLE && interrupt && !irq_mask_q;
    assign state      = state_q;
    assign retired    = retired_q;

    // Next-state, retirement and per-state strobe decode; strobes held low in reset
    always_comb begin
        state_d       = S_FETCH;
        retire_c      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        irq_ack       = 1'b0;
        illegal_op    = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (irq_take_c) begin
                    state_d = S_IRQ;
                end else begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    state_d   = mem_ready ? S_DECODE : S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                state_d  = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire_c   = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                retire_c  = mem_ready;
                state_d   = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire_c  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                retire_c      = 1'b1;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                retire_c  = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                retire_c  = 1'b1;
            end
            S_IRQ: begin
                pc_write  = 1'b1;
                pc_source = 2'b11;
                irq_ack   = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        if (!reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            pc_source     = 2'b00;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            irq_ack       = 1'b0;
            illegal_op    = 1'b0;
        end
    end

    // State, retirement counter and interrupt mask; mask lifts once an instruction retires
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            retired_q  <= '0;
            irq_mask_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire_c) begin
                retired_q  <= retired_q + CNT_WIDTH'(1);
                irq_mask_q <= 1'b0;
            end else if (state_q == S_IRQ) begin
                irq_mask_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-cycle expectations queued by the driver,
// compared at the falling edge. dut2 runs with IRQ disabled and a 4-bit counter.
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       irq_ack;
        logic       illegal_op;
    } strb_t;

    typedef struct {
        bit          sel;
        logic [3:0]  st;
        strb_t       sb;
        logic [15:0] ret;
    } exp_t;

    logic clock;
    logic reset1 = 1'b0, mem_ready1 = 1'b1, interrupt1 = 1'b0;
    logic reset2 = 1'b0, mem_ready2 = 1'b1, interrupt2 = 1'b0;
    logic [5:0] opcode1 = 6'd0, opcode2 = 6'd0;

    strb_t       obs1, obs2;
    logic [3:0]  state1, state2;
    logic [15:0] retired1;
    logic [3:0]  retired2;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_ret1 = 0;
    int   exp_ret2 = 0;

    initial begin
        clock = 1'b1;
        forever #5 clock = ~clock;
    end

    mips_multicycle_ctrl #(.IRQ_ENABLE(1'b1), .CNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset1), .opcode(opcode1),
        .mem_ready(mem_ready1), .interrupt(interrupt1),
        .pc_write(obs1.pc_write), .pc_write_cond(obs1.pc_write_cond),
        .pc_source(obs1.pc_source), .i_or_d(obs1.i_or_d),
        .mem_read(obs1.mem_read), .mem_write(obs1.mem_write),
        .ir_write(obs1.ir_write), .mem_to_reg(obs1.mem_to_reg),
        .reg_dst(obs1.reg_dst), .reg_write(obs1.reg_write),
        .alu_src_a(obs1.alu_src_a), .alu_src_b(obs1.alu_src_b),
        .alu_op(obs1.alu_op), .irq_ack(obs1.irq_ack),
        .illegal_op(obs1.illegal_op), .state(state1), .retired(retired1)
    );

    mips_multicycle_ctrl #(.IRQ_ENABLE(1'b0), .CNT_WIDTH(4)) dut2 (
        .clock(clock), .reset(reset2), .opcode(opcode2),
        .mem_ready(mem_ready2), .interrupt(interrupt2),
        .pc_write(obs2.pc_write), .pc_write_cond(obs2.pc_write_cond),
        .pc_source(obs2.pc_source), .i_or_d(obs2.i_or_d),
        .mem_read(obs2.mem_read), .mem_write(obs2.mem_write),
        .ir_write(obs2.ir_write), .mem_to_reg(obs2.mem_to_reg),
        .reg_dst(obs2.reg_dst), .reg_write(obs2.reg_write),
        .alu_src_a(obs2.alu_src_a), .alu_src_b(obs2.alu_src_b),
        .alu_op(obs2.alu_op), .irq_ack(obs2.irq_ack),
        .illegal_op(obs2.illegal_op), .state(state2), .retired(retired2)
    );

    // Count one comparison and report it on mismatch
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Strobe set each state should show (zero while reset is low or an IRQ is being taken)
    function automatic strb_t exp_strb(input int st, input bit mr, input bit take,
                                       input bit ill, input bit in_reset);
        strb_t s;
        s = '0;
        if (!in_reset) begin
            case (st)
                0: if (!take) begin
                       s.mem_read = 1'b1; s.alu_src_b = 2'b01;
                       s.ir_write = mr;   s.pc_write  = mr;
                   end
                1: begin s.alu_src_b = 2'b11; s.illegal_op = ill; end
                2: begin s.alu_src_a = 1'b1; s.alu_src_b = 2'b10; end
                3: begin s.mem_read = 1'b1; s.i_or_d = 1'b1; end
                4: begin s.reg_write = 1'b1; s.mem_to_reg = 1'b1; end
                5: begin s.mem_write = 1'b1; s.i_or_d = 1'b1; end
                6: begin s.alu_src_a = 1'b1; s.alu_op = 2'b10; end
                7: begin s.reg_write = 1'b1; s.reg_dst = 1'b1; end
                8: begin s.alu_src_a = 1'b1; s.alu_op = 2'b01;
                         s.pc_write_cond = 1'b1; s.pc_source = 2'b01; end
                9: begin s.pc_write = 1'b1; s.pc_source = 2'b10; end
                10: begin s.alu_src_a = 1'b1; s.alu_src_b = 2'b10; end
                11: s.reg_write = 1'b1;
                12: begin s.pc_write = 1'b1; s.pc_source = 2'b11; s.irq_ack = 1'b1; end
                default: s = '0;
            endcase
        end
        return s;
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show in it
    task automatic cyc(input bit sel, input bit rst, input int st, input logic [5:0] op,
                       input bit mr, input bit irq, input bit take, input bit ill,
                       input bit ret);
        exp_t e;
        if (!sel) begin
            reset1 = rst; opcode1 = op; mem_ready1 = mr; interrupt1 = irq;
            if (!rst) exp_ret1 = 0;
        end else begin
            reset2 = rst; opcode2 = op; mem_ready2 = mr; interrupt2 = irq;
            if (!rst) exp_ret2 = 0;
        end
        e.sel = sel;
        e.st  = 4'(st);
        e.sb  = exp_strb(st, mr, take, ill, !rst);
        e.ret = sel ? 16'(exp_ret2 % 16) : 16'(exp_ret1 % 65536);
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        if (ret && rst) begin
            if (sel) exp_ret2++; else exp_ret1++;
        end
    endtask

    // Main-instance shorthand: reset released, no interrupt
    task automatic c1(input int st, input logic [5:0] op, input bit mr, input bit ret);
        cyc(1'b0, 1'b1, st, op, mr, 1'b0, 1'b0, 1'b0, ret);
    endtask

    // Pop one expectation per falling edge and compare against the selected instance
    always @(negedge clock) begin : mon
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            if (!e.sel) begin
                chk("state",   32'(state1),   32'(e.st));
                chk("strobes", 32'(obs1),     32'(e.sb));
                chk("retired", 32'(retired1), 32'(e.ret));
            end else begin
                chk("state2",   32'(state2),   32'(e.st));
                chk("strobes2", 32'(obs2),     32'(e.sb));
                chk("retired2", 32'(retired2), 32'(e.ret));
            end
        end
    end

    initial begin
        // reset held low
        cyc(0, 0, 0, OP_R, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, OP_R, 1, 0, 0, 0, 0);
        // R-type: 0,1,6,7
        c1(0, OP_R, 1, 0); c1(1, OP_R, 1, 0); c1(6, OP_R, 1, 0); c1(7, OP_R, 1, 1);
        // lw with three wait cycles in MEMRD
        c1(0, OP_LW, 1, 0); c1(1, OP_LW, 1, 0); c1(2, OP_LW, 1, 0);
        c1(3, OP_LW, 0, 0); c1(3, OP_LW, 0, 0); c1(3, OP_LW, 0, 0); c1(3, OP_LW, 1, 0);
        c1(4, OP_LW, 1, 1);
        // sw with a fetch stall and a write stall
        c1(0, OP_SW, 0, 0); c1(0, OP_SW, 1, 0); c1(1, OP_SW, 1, 0); c1(2, OP_SW, 1, 0);
        c1(5, OP_SW, 0, 0); c1(5, OP_SW, 1, 1);
        // beq, j, addi
        c1(0, OP_BEQ, 1, 0); c1(1, OP_BEQ, 1, 0); c1(8, OP_BEQ, 1, 1);
        c1(0, OP_J, 1, 0); c1(1, OP_J, 1, 0); c1(9, OP_J, 1, 1);
        c1(0, OP_ADDI, 1, 0); c1(1, OP_ADDI, 1, 0); c1(10, OP_ADDI, 1, 0); c1(11, OP_ADDI, 1, 1);
        // undefined opcode: illegal pulse, back to FETCH, nothing retired
        c1(0, OP_BAD, 1, 0);
        cyc(0, 1, 1, OP_BAD, 1, 0, 0, 1, 0);
        c1(0, OP_J, 1, 0); c1(1, OP_J, 1, 0); c1(9, OP_J, 1, 1);
        // interrupt held: IRQ, one instruction masked through, IRQ again
        cyc(0, 1, 0,  OP_R, 1, 1, 1, 0, 0);
        cyc(0, 1, 12, OP_R, 1, 1, 0, 0, 0);
        cyc(0, 1, 0,  OP_R, 1, 1, 0, 0, 0);
        cyc(0, 1, 1,  OP_R, 1, 1, 0, 0, 0);
        cyc(0, 1, 6,  OP_R, 1, 1, 0, 0, 0);
        cyc(0, 1, 7,  OP_R, 1, 1, 0, 0, 1);
        cyc(0, 1, 0,  OP_R, 1, 1, 1, 0, 0);
        cyc(0, 1, 12, OP_R, 1, 1, 0, 0, 0);
        c1(0, OP_BEQ, 1, 0); c1(1, OP_BEQ, 1, 0); c1(8, OP_BEQ, 1, 1);
        // reset pulsed while MEMWR is stalled
        c1(0, OP_SW, 1, 0); c1(1, OP_SW, 1, 0); c1(2, OP_SW, 1, 0); c1(5, OP_SW, 0, 0);
        cyc(0, 0, 0, OP_SW, 0, 0, 0, 0, 0);
        c1(0, OP_J, 1, 0); c1(1, OP_J, 1, 0); c1(9, OP_J, 1, 1);
        c1(0, OP_J, 1, 0);

        // IRQ disabled, 4-bit counter: 16 addi with interrupt high wraps to 0
        for (int i = 0; i < 16; i++) begin
            cyc(1, 1, 0,  OP_ADDI, 1, 1, 0, 0, 0);
            cyc(1, 1, 1,  OP_ADDI, 1, 1, 0, 0, 0);
            cyc(1, 1, 10, OP_ADDI, 1, 1, 0, 0, 0);
            cyc(1, 1, 11, OP_ADDI, 1, 1, 0, 0, 1);
        end
        cyc(1, 1, 0, OP_ADDI, 1, 1, 0, 0, 0);
        chk("wrap_count", 32'(exp_ret2 % 16), 32'(retired2));

        chk("drain", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
